// File: rtl/lcd_char_feeder.sv
// -----------------------------------------------------------------------------
// lcd_char_feeder
//
// Upstream feeder for the LCD text box. Bytes written by the CPU output port
// are buffered in a small FIFO, filtered (control codes dropped, bit 7
// ignored) and presented to the LCD one at a time as a 7-bit character code
// with a level strobe. Each strobe is high for HOLD cycles and is followed by
// at least GAP low cycles, so the LCD's edge detector registers exactly one
// character per strobe. Line occupancy is tracked. A newline, or a printable
// character arriving on a full line, produces a clear_line pulse. In the
// full-line case the character is then shown on the fresh line.
//
// Ports:
//   clk_50      in   system clock (50 MHz)
//   reset       in   asynchronous, active-high reset
//   wr_en       in   CPU output-port write strobe
//   wr_data     in   [7:0] byte written
//   wr_ready    out  FIFO not full (combinational)
//   char_code   out  [6:0] character to the LCD text box
//   add_input   out  character strobe to the LCD
//   clear_line  out  line-clear pulse (drives the text-box reset)
//   count       out  [4:0] characters on the current line, 0..SYMBOLS
//   fifo_level  out  [FIFO_AW:0] current FIFO occupancy
//   overflow    out  sticky: a write was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module lcd_char_feeder #(
  parameter int FIFO_AW    = 3,
  parameter int SYMBOLS    = 16,
  parameter int HOLD       = 2,
  parameter int GAP        = 2,
  parameter int CLR_CYCLES = 2
) (
  input  logic               clk_50,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [7:0]         wr_data,
  output logic               wr_ready,
  output logic [6:0]         char_code,
  output logic               add_input,
  output logic               clear_line,
  output logic [4:0]         count,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               overflow
);

  localparam int               DEPTH    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_LVL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [4:0]       LINE_MAX = 5'(SYMBOLS);
  localparam logic [7:0]       HOLD_T   = 8'(HOLD - 1);
  localparam logic [7:0]       GAP_T    = 8'(GAP - 1);
  localparam logic [7:0]       CLR_T    = 8'(CLR_CYCLES - 1);
  localparam logic [6:0]       NEWLINE  = 7'h0A;
  localparam logic [6:0]       FIRST_PR = 7'h20;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_ASSERT,
    S_GAP
  } state_t;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic [6:0]         head_code;

  state_t             state;
  logic [7:0]         timer;
  logic               pending;

  // Full is taken from the registered level, i.e. before any same-cycle pop,
  // so a write into a full FIFO is refused even when the FSM pops that cycle.
  assign full      = (fifo_level == FULL_LVL);
  assign empty     = (fifo_level == '0);
  assign wr_ready  = !full;
  assign push      = wr_en && !full;
  assign pop       = (state == S_IDLE) && !empty;
  assign head_code = mem[rd_ptr][6:0];

  // NOTE: the storage array has no reset; only the pointers and level
  // define which entries are valid, so clearing the data would only add
  // reset fan-out and keep the array from mapping onto RAM.
  always_ff @(posedge clk_50) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      // Pointers are exactly FIFO_AW bits wide, so they wrap modulo depth.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
      if (wr_en && full) overflow <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Character FSM. All LCD-facing outputs are registered here.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      timer      <= '0;
      pending    <= 1'b0;
      char_code  <= '0;
      add_input  <= 1'b0;
      clear_line <= 1'b0;
      count      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!empty) begin
            if (head_code == NEWLINE) begin
              pending    <= 1'b0;
              clear_line <= 1'b1;
              count      <= '0;
              timer      <= CLR_T;
              state      <= S_CLEAR;
            end else if (head_code < FIRST_PR) begin
              // Non-newline control code: consumed and dropped.
              state <= S_IDLE;
            end else if (count == LINE_MAX) begin
              // Line full: clear first, then show this character.
              char_code  <= head_code;
              pending    <= 1'b1;
              clear_line <= 1'b1;
              count      <= '0;
              timer      <= CLR_T;
              state      <= S_CLEAR;
            end else begin
              char_code <= head_code;
              add_input <= 1'b1;
              timer     <= HOLD_T;
              state     <= S_ASSERT;
            end
          end
        end

        S_CLEAR: begin
          count <= '0;
          if (timer == '0) begin
            clear_line <= 1'b0;
            if (pending) begin
              pending   <= 1'b0;
              add_input <= 1'b1;
              timer     <= HOLD_T;
              state     <= S_ASSERT;
            end else begin
              timer <= GAP_T;
              state <= S_GAP;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end

        S_ASSERT: begin
          if (timer == '0) begin
            add_input <= 1'b0;
            if (count != LINE_MAX) count <= count + 1'b1;
            timer <= GAP_T;
            state <= S_GAP;
          end else begin
            timer <= timer - 1'b1;
          end
        end

        S_GAP: begin
          if (timer == '0) state <= S_IDLE;
          else             timer <= timer - 1'b1;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_char_feeder.sv
// -----------------------------------------------------------------------------
// tb_lcd_char_feeder
//
// Self-checking bench for lcd_char_feeder with default parameters
// (FIFO_AW=3, SYMBOLS=16, HOLD=2, GAP=2, CLR_CYCLES=2). A reference model of
// the line logic pushes expected strobe / clear events into a scoreboard as
// bytes are written. A monitor pops and compares them as the DUT raises
// add_input or clear_line, and checks pulse widths and gaps.
// -----------------------------------------------------------------------------
module tb_lcd_char_feeder;

  localparam int FIFO_AW    = 3;
  localparam int SYMBOLS    = 16;
  localparam int HOLD       = 2;
  localparam int GAP        = 2;
  localparam int CLR_CYCLES = 2;

  logic             clk_50 = 1'b0;
  logic             reset  = 1'b1;
  logic             wr_en  = 1'b0;
  logic [7:0]       wr_data = 8'h00;
  logic             wr_ready;
  logic [6:0]       char_code;
  logic             add_input;
  logic             clear_line;
  logic [4:0]       count;
  logic [FIFO_AW:0] fifo_level;
  logic             overflow;

  lcd_char_feeder #(
    .FIFO_AW   (FIFO_AW),
    .SYMBOLS   (SYMBOLS),
    .HOLD      (HOLD),
    .GAP       (GAP),
    .CLR_CYCLES(CLR_CYCLES)
  ) dut (
    .clk_50    (clk_50),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .char_code (char_code),
    .add_input (add_input),
    .clear_line(clear_line),
    .count     (count),
    .fifo_level(fifo_level),
    .overflow  (overflow)
  );

  always #10 clk_50 = ~clk_50;

  typedef enum {EV_STROBE, EV_CLEAR} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [6:0] code;
  } ev_t;

  ev_t sb[$];
  int  tests = 0;
  int  fails = 0;
  int  n_strobes = 0;
  int  n_clears = 0;
  int  model_count = 0;

  // Reference model of the line logic for one accepted byte.
  task automatic model_byte(input logic [7:0] b);
    logic [6:0] c;
    ev_t e;
    c = b[6:0];
    if (c == 7'h0A) begin
      e.kind = EV_CLEAR; e.code = 7'h00; sb.push_back(e);
      model_count = 0;
    end else if (c < 7'h20) begin
      // dropped
    end else if (model_count == SYMBOLS) begin
      e.kind = EV_CLEAR; e.code = 7'h00; sb.push_back(e);
      e.kind = EV_STROBE; e.code = c; sb.push_back(e);
      model_count = 1;
    end else begin
      e.kind = EV_STROBE; e.code = c; sb.push_back(e);
      model_count = model_count + 1;
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    logic       prev_add, prev_clr, seen_fall;
    int         hold_cnt, clr_cnt, low_cnt;
    logic [6:0] held_code;
    ev_t        e;
    prev_add = 0; prev_clr = 0; seen_fall = 0;
    hold_cnt = 0; clr_cnt = 0; low_cnt = 0; held_code = '0;
    forever begin
      @(negedge clk_50);
      if (reset) begin
        prev_add = 0; prev_clr = 0; seen_fall = 0;
        hold_cnt = 0; clr_cnt = 0; low_cnt = 0;
      end else begin
        if (add_input && !prev_add) begin
          n_strobes++;
          tests++;
          if (seen_fall && low_cnt < GAP) begin
            fails++;
            $display("FAIL strobe_gap: low for %0d cycles, need >= %0d", low_cnt, GAP);
          end
          tests++;
          if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_strobe: char_code=%h, none expected", char_code);
          end else begin
            e = sb.pop_front();
            if (e.kind != EV_STROBE || char_code !== e.code) begin
              fails++;
              $display("FAIL strobe_event: got strobe code=%h, expected kind=%0d code=%h",
                       char_code, e.kind, e.code);
            end
          end
          hold_cnt = 1; held_code = char_code;
        end else if (add_input) begin
          hold_cnt++;
          tests++;
          if (char_code !== held_code) begin
            fails++;
            $display("FAIL code_stable: char_code=%h during strobe, expected %h", char_code, held_code);
          end
        end else if (prev_add) begin
          tests++;
          if (hold_cnt != HOLD) begin
            fails++;
            $display("FAIL strobe_width: high %0d cycles, expected %0d", hold_cnt, HOLD);
          end
          seen_fall = 1; low_cnt = 1;
        end else begin
          low_cnt++;
        end

        if (clear_line && !prev_clr) begin
          n_clears++;
          tests++;
          if (count !== 5'd0) begin
            fails++;
            $display("FAIL clear_count: count=%0d at clear, expected 0", count);
          end
          tests++;
          if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_clear: no clear expected");
          end else begin
            e = sb.pop_front();
            if (e.kind != EV_CLEAR) begin
              fails++;
              $display("FAIL clear_event: got clear, expected strobe code=%h", e.code);
            end
          end
          clr_cnt = 1;
        end else if (clear_line) begin
          clr_cnt++;
        end else if (prev_clr) begin
          tests++;
          if (clr_cnt != CLR_CYCLES) begin
            fails++;
            $display("FAIL clear_width: high %0d cycles, expected %0d", clr_cnt, CLR_CYCLES);
          end
        end
        prev_add = add_input;
        prev_clr = clear_line;
      end
    end
  end

  // Flow-controlled write: waits (bounded) for wr_ready, then writes one byte.
  task automatic write_byte(input logic [7:0] b);
    int waited;
    waited = 0;
    @(negedge clk_50);
    while (!wr_ready && waited < 200) begin
      @(negedge clk_50);
      waited++;
    end
    tests++;
    if (!wr_ready) begin
      fails++;
      $display("FAIL write_timeout: wr_ready=%b after %0d cycles, expected 1", wr_ready, waited);
    end else begin
      wr_en = 1'b1; wr_data = b;
      model_byte(b);
      @(posedge clk_50);
      #1 wr_en = 1'b0;
    end
  endtask

  // Waits (bounded) until every expected event has been seen and the DUT is quiet.
  task automatic drain(input int budget);
    int n;
    n = 0;
    while (n < budget && !(sb.size() == 0 && fifo_level == 0 && !add_input && !clear_line)) begin
      @(negedge clk_50);
      n++;
    end
    repeat (GAP + 3) @(negedge clk_50);
    tests++;
    if (sb.size() != 0 || fifo_level != 0) begin
      fails++;
      $display("FAIL drain: %0d events pending, fifo_level=%0d, expected 0/0", sb.size(), fifo_level);
    end
    tests++;
    if (count !== 5'(model_count)) begin
      fails++;
      $display("FAIL line_count: count=%0d, expected %0d", count, model_count);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_50);
    #2 reset = 1'b1;
    wr_en = 1'b0;
    sb.delete();
    model_count = 0;
    repeat (2) @(negedge clk_50);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #5;
    tests++;
    if ({char_code, add_input, clear_line, count, fifo_level, overflow} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: code=%h add=%b clr=%b count=%0d lvl=%0d ovf=%b, expected all 0",
               char_code, add_input, clear_line, count, fifo_level, overflow);
    end
    tests++;
    if (wr_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: wr_ready=%b, expected 1", wr_ready);
    end
    repeat (2) @(negedge clk_50);
    reset = 1'b0;
  endtask

  task automatic test_single();
    logic exp_add [5];
    int s0;
    exp_add = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    s0 = n_strobes;
    @(negedge clk_50);
    wr_en = 1'b1; wr_data = 8'h41;
    model_byte(8'h41);
    @(posedge clk_50);               // edge k
    #1 wr_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_50);             // after edge k+i
      tests++;
      if (add_input !== exp_add[i]) begin
        fails++;
        $display("FAIL latency: add_input=%b after edge k+%0d, expected %b", add_input, i, exp_add[i]);
      end
      if (exp_add[i]) begin
        tests++;
        if (char_code !== 7'h41) begin
          fails++;
          $display("FAIL single_code: char_code=%h, expected 41", char_code);
        end
      end
    end
    drain(50);
    tests++;
    if (n_strobes - s0 != 1) begin
      fails++;
      $display("FAIL single_strobes: %0d strobes, expected 1", n_strobes - s0);
    end
  endtask

  task automatic test_line_wrap();
    int s0, c0;
    do_reset();
    s0 = n_strobes; c0 = n_clears;
    for (int i = 0; i < 17; i++) write_byte(8'(8'h41 + i));
    drain(600);
    tests++;
    if (n_strobes - s0 != 17 || n_clears - c0 != 1) begin
      fails++;
      $display("FAIL wrap_counts: strobes=%0d clears=%0d, expected 17/1", n_strobes - s0, n_clears - c0);
    end
    tests++;
    if (char_code !== 7'h51) begin
      fails++;
      $display("FAIL wrap_last_code: char_code=%h, expected 51", char_code);
    end
  endtask

  task automatic test_newline_ctrl();
    int s0, c0;
    s0 = n_strobes; c0 = n_clears;
    write_byte(8'h42);
    write_byte(8'h0A);
    write_byte(8'h43);
    drain(100);
    tests++;
    if (n_strobes - s0 != 2 || n_clears - c0 != 1) begin
      fails++;
      $display("FAIL newline_counts: strobes=%0d clears=%0d, expected 2/1", n_strobes - s0, n_clears - c0);
    end
    s0 = n_strobes; c0 = n_clears;
    write_byte(8'h07);
    drain(50);
    tests++;
    if (n_strobes - s0 != 0 || n_clears - c0 != 0) begin
      fails++;
      $display("FAIL ctrl_dropped: strobes=%0d clears=%0d, expected 0/0", n_strobes - s0, n_clears - c0);
    end
  endtask

  task automatic test_bit7();
    write_byte(8'hC1);
    drain(50);
    tests++;
    if (char_code !== 7'h41) begin
      fails++;
      $display("FAIL bit7_ignored: char_code=%h, expected 41", char_code);
    end
  endtask

  task automatic test_overflow();
    int s0;
    do_reset();
    s0 = n_strobes;
    // One character first so the FSM is busy while the burst arrives.
    @(negedge clk_50);
    wr_en = 1'b1; wr_data = 8'h30;
    model_byte(8'h30);
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk_50);
      if (n == 10) begin
        tests++;
        if (fifo_level !== 4'd8 || wr_ready !== 1'b0 || overflow !== 1'b0) begin
          fails++;
          $display("FAIL full_state: lvl=%0d ready=%b ovf=%b, expected 8/0/0", fifo_level, wr_ready, overflow);
        end
      end
      if (n == 11) begin
        tests++;
        if (overflow !== 1'b1 || fifo_level !== 4'd8) begin
          fails++;
          $display("FAIL refused_write: ovf=%b lvl=%0d, expected 1/8", overflow, fifo_level);
        end
      end
      if (n == 12) begin
        // A write against a full FIFO is refused even though this edge popped.
        tests++;
        if (fifo_level !== 4'd7) begin
          fails++;
          $display("FAIL full_before_pop: lvl=%0d, expected 7", fifo_level);
        end
      end
      wr_data = 8'(8'h30 + n);
      if (n <= 9 || n == 12) model_byte(wr_data);
    end
    @(negedge clk_50);
    wr_en = 1'b0;
    tests++;
    if (fifo_level !== 4'd8) begin
      fails++;
      $display("FAIL refill: lvl=%0d, expected 8", fifo_level);
    end
    drain(300);
    tests++;
    if (n_strobes - s0 != 11 || overflow !== 1'b1) begin
      fails++;
      $display("FAIL burst_accepted: strobes=%0d ovf=%b, expected 11/1", n_strobes - s0, overflow);
    end
    do_reset();
    tests++;
    if (overflow !== 1'b0) begin
      fails++;
      $display("FAIL overflow_clear: ovf=%b after reset, expected 0", overflow);
    end
  endtask

  task automatic test_reset_mid();
    int s0;
    do_reset();
    for (int i = 0; i < 5; i++) write_byte(8'(8'h61 + i));
    repeat (3) @(negedge clk_50);
    tests++;
    if (add_input !== 1'b1 || fifo_level !== 4'd3) begin
      fails++;
      $display("FAIL mid_setup: add=%b lvl=%0d, expected 1/3", add_input, fifo_level);
    end
    #3 reset = 1'b1;
    #1;
    tests++;
    if ({add_input, clear_line, count, fifo_level, overflow, char_code} !== '0) begin
      fails++;
      $display("FAIL async_reset: add=%b clr=%b count=%0d lvl=%0d ovf=%b code=%h, expected all 0",
               add_input, clear_line, count, fifo_level, overflow, char_code);
    end
    sb.delete();
    model_count = 0;
    repeat (2) @(negedge clk_50);
    reset = 1'b0;
    s0 = n_strobes;
    repeat (20) @(negedge clk_50);
    tests++;
    if (n_strobes != s0 || fifo_level !== 4'd0 || add_input !== 1'b0) begin
      fails++;
      $display("FAIL post_reset_quiet: strobes=%0d lvl=%0d add=%b, expected 0/0/0",
               n_strobes - s0, fifo_level, add_input);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_line_wrap();
    test_newline_ctrl();
    test_bit7();
    test_overflow();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
